// File: rtl/z_core_mem_ctrl.sv
// z_core_mem_ctrl -- data-memory controller between z_core_control_u and a
// single-port synchronous word RAM.
//
// Handles RV32I access sizes: word stores go straight to the RAM, byte and
// half stores use a read-modify-write, and loads are lane-extracted and
// sign- or zero-extended. Only one request is in flight at a time, and each
// request completes with a one-cycle core_ready pulse.
//
// Optional feature: define Z_CORE_MEM_FAULT_EN to enable fault checking.
// With it, a request faults if it is a misaligned half, a misaligned word,
// uses the reserved size, or sets any address bit above the RAM. A faulted
// request gets core_ready and core_err in the cycle after acceptance and
// never touches the RAM. Without it, core_err is always 0, size 11 acts as
// a word, and misaligned half/word accesses use the containing aligned word.
//
// Parameters:
//   ADDR_W         RAM word-address width (RAM depth = 2**ADDR_W words)
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   core_req       request, sampled only while idle
//   core_we        1 = store, 0 = load
//   core_addr      byte address
//   core_wdata     store data, right-aligned
//   core_size      00 byte, 01 half, 10 word, 11 reserved
//   core_unsigned  zero-extend sub-word loads
//   core_rdata     load result, valid with core_ready (0 for stores)
//   core_ready     one-cycle completion pulse
//   core_err       access fault, valid with core_ready
//   mem_en/mem_we  RAM enable / write enable
//   mem_addr       RAM word address (core_addr[ADDR_W+1:2])
//   mem_wdata      RAM write word
//   mem_rdata      RAM read word, valid the cycle after a read enable
module z_core_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [1:0]        core_size,
  input  logic              core_unsigned,
  output logic [31:0]       core_rdata,
  output logic              core_ready,
  output logic              core_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_t      state;

  // Request fields latched at acceptance; only the bits the later states use.
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [1:0]  req_lane;
  logic [15:0] req_wdata;

  logic        fault;

`ifdef Z_CORE_MEM_FAULT_EN
  assign fault = (core_size == 2'b11)
              || ((core_size == SZ_HALF) && core_addr[0])
              || ((core_size == 2'b10) && (core_addr[1:0] != 2'b00))
              || (|core_addr[31:ADDR_W+2]);
`else
  assign fault = 1'b0;
  // Upper address bits are deliberately ignored: the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^core_addr[31:ADDR_W+2];
`endif

  // Replace the selected byte/half lane of a RAM word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [15:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] m;
    m = word;
    if (size == SZ_BYTE) m[{lane, 3'b000} +: 8] = data[7:0];
    else                 m[{lane[1], 4'b0000} +: 16] = data;
    return m;
  endfunction

  // Pull the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // All outputs are registered here alongside the state. The registered
  // mem_wdata / core_rdata values double as the buffer for the word read
  // back in CAP.
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset is synchronous and sits inside the clocked block; it
      // also clears the latched request so nothing stale survives it.
      state        <= S_IDLE;
      req_we       <= 1'b0;
      req_size     <= 2'b00;
      req_unsigned <= 1'b0;
      req_lane     <= 2'b00;
      req_wdata    <= 16'h0;
      core_rdata   <= 32'h0;
      core_ready   <= 1'b0;
      core_err     <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_req) begin
            req_we       <= core_we;
            req_size     <= core_size;
            req_unsigned <= core_unsigned;
            req_lane     <= core_addr[1:0];
            req_wdata    <= core_wdata[15:0];
            mem_addr     <= core_addr[ADDR_W+1:2];
            if (fault) begin
              state      <= S_RESP;
              core_ready <= 1'b1;
              core_err   <= 1'b1;
              core_rdata <= 32'h0;
            end else if (core_we && core_size[1]) begin
              // Word store (and reserved size): no read needed.
              state     <= S_WR;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= core_wdata;
            end else begin
              state  <= S_RD;
              mem_en <= 1'b1;
              mem_we <= 1'b0;
            end
          end
        end

        S_RD: begin
          mem_en <= 1'b0;
          state  <= S_CAP;
        end

        S_CAP: begin
          if (req_we) begin
            state     <= S_WR;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= merge_lane(mem_rdata, req_wdata, req_size, req_lane);
          end else begin
            state      <= S_RESP;
            core_ready <= 1'b1;
            core_rdata <= extract_lane(mem_rdata, req_size, req_lane, req_unsigned);
          end
        end

        S_WR: begin
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          state      <= S_RESP;
          core_ready <= 1'b1;
          core_rdata <= 32'h0;
        end

        S_RESP: begin
          core_ready <= 1'b0;
          core_err   <= 1'b0;
          core_rdata <= 32'h0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z_core_mem_ctrl.sv
// Testbench for z_core_mem_ctrl. Stimulus pushes expected responses, RAM
// reads and RAM writes into queues; a monitor on the falling edge pops and
// compares whenever the DUT shows core_ready or a RAM access.
module tb_z_core_mem_ctrl;

`ifdef Z_CORE_MEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req;
  logic              core_we;
  logic [31:0]       core_addr;
  logic [31:0]       core_wdata;
  logic [1:0]        core_size;
  logic              core_unsigned;
  logic [31:0]       core_rdata;
  logic              core_ready;
  logic              core_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  z_core_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_size    (core_size),
    .core_unsigned(core_unsigned),
    .core_rdata   (core_rdata),
    .core_ready   (core_ready),
    .core_err     (core_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge it holds the number of the last rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM environment.
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  resp_t resp_q[$];
  acc_t  rd_q[$];
  acc_t  wr_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every completion and RAM access against the queues.
  resp_t r;
  acc_t  a;
  always @(negedge clk) begin
    if (core_ready) begin
      if (resp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready actual=ready@%0d rdata=%h expected=no_ready", cyc, core_rdata);
      end else begin
        r = resp_q.pop_front();
        check("resp_rdata", core_rdata, r.rdata);
        check("resp_err", {31'b0, core_err}, {31'b0, r.err});
        check("resp_cycle", cyc, r.cyc);
      end
    end
    if (mem_en && mem_we) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=addr %h data %h expected=no_write", mem_addr, mem_wdata);
      end else begin
        a = wr_q.pop_front();
        check("wr_addr", {22'b0, mem_addr}, a.addr);
        check("wr_data", mem_wdata, a.data);
        check("wr_cycle", cyc, a.cyc);
      end
    end
    if (mem_en && !mem_we) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read actual=addr %h expected=no_read", mem_addr);
      end else begin
        a = rd_q.pop_front();
        check("rd_addr", {22'b0, mem_addr}, a.addr);
        check("rd_cycle", cyc, a.cyc);
      end
    end
  end

  // One request from an idle controller. exp_rdata / exp_wword are
  // hand-computed; faulty marks requests that fault when checking is enabled.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit uns,
                        input logic [31:0] exp_rdata, input logic [31:0] exp_wword,
                        input bit faulty);
    int acc;
    int lat;
    bit flt;
    resp_t er;
    acc_t  ea;
    flt = faulty && FAULT_EN;
    if (flt)                        lat = 1;
    else if (we && size == 2'b10)   lat = 2;
    else if (we)                    lat = 4;
    else                            lat = 3;
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    core_size = size; core_unsigned = uns;
    @(posedge clk);
    #1 acc = cyc;
    er.rdata = (flt || we) ? 32'h0 : exp_rdata;
    er.err   = flt;
    er.cyc   = acc + lat - 1;
    resp_q.push_back(er);
    if (!flt && !(we && size == 2'b10)) begin
      ea.addr = {22'b0, addr[ADDR_W+1:2]}; ea.data = 32'h0; ea.cyc = acc;
      rd_q.push_back(ea);
    end
    if (!flt && we) begin
      ea.addr = {22'b0, addr[ADDR_W+1:2]}; ea.data = exp_wword; ea.cyc = acc + lat - 2;
      wr_q.push_back(ea);
    end
    // Scramble inputs after acceptance; they must have no effect.
    @(negedge clk);
    core_req = 1'b0; core_we = ~we; core_addr = 32'hFFFF_FFFF;
    core_wdata = 32'h0; core_size = 2'b00; core_unsigned = ~uns;
    repeat (lat) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    resp_t er;
    acc_t  ea;
    reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0;
    core_wdata = 32'h0; core_size = 2'b00; core_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_core_ready", {31'b0, core_ready}, 32'h0);
    check("rst_core_err", {31'b0, core_err}, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    //     we  addr          wdata         size   uns  exp_rdata     exp_wword     faulty
    do_req(1, 32'h10,       32'hDEADBEEF, 2'b10, 0,   32'h0,        32'hDEADBEEF, 0); // SW
    do_req(1, 32'h11,       32'h0000005A, 2'b00, 0,   32'h0,        32'hDEAD5AEF, 0); // SB
    do_req(0, 32'h13,       32'h0,        2'b00, 0,   32'hFFFFFFDE, 32'h0,        0); // LB
    do_req(0, 32'h13,       32'h0,        2'b00, 1,   32'h000000DE, 32'h0,        0); // LBU
    do_req(0, 32'h12,       32'h0,        2'b01, 0,   32'hFFFFDEAD, 32'h0,        0); // LH
    do_req(0, 32'h10,       32'h0,        2'b10, 1,   32'hDEAD5AEF, 32'h0,        0); // LW
    do_req(1, 32'h0,        32'h11223344, 2'b10, 0,   32'h0,        32'h11223344, 0); // SW @0

    // Two LW @0 with core_req held high: second accepted 4 edges later.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0; core_size = 2'b10; core_unsigned = 1'b0;
    @(posedge clk);
    #1 acc = cyc;
    er.rdata = 32'h11223344; er.err = 1'b0;
    er.cyc = acc + 2; resp_q.push_back(er);
    er.cyc = acc + 6; resp_q.push_back(er);
    ea.addr = 32'h0; ea.data = 32'h0;
    ea.cyc = acc;     rd_q.push_back(ea);
    ea.cyc = acc + 4; rd_q.push_back(ea);
    repeat (4) @(posedge clk);
    @(negedge clk);
    core_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the RD cycle of SH 0x1234 @0x10: no write, no ready.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'h1234;
    core_size = 2'b01; core_unsigned = 1'b0;
    @(posedge clk);
    #1 acc = cyc;
    ea.addr = 32'h4; ea.data = 32'h0; ea.cyc = acc;
    rd_q.push_back(ea);
    @(negedge clk);
    core_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_mem_en", {31'b0, mem_en}, 32'h0);
    check("abort_mem_we", {31'b0, mem_we}, 32'h0);
    repeat (4) @(negedge clk);

    //     we  addr          wdata         size   uns  exp_rdata     exp_wword     faulty
    do_req(0, 32'h10,       32'h0,        2'b10, 0,   32'hDEAD5AEF, 32'h0,        0); // LW unchanged
    do_req(1, 32'h12,       32'h0000BEEF, 2'b01, 0,   32'h0,        32'hBEEF5AEF, 0); // SH upper
    do_req(0, 32'h12,       32'h0,        2'b01, 1,   32'h0000BEEF, 32'h0,        0); // LHU
    do_req(0, 32'h10,       32'h0,        2'b01, 0,   32'h00005AEF, 32'h0,        0); // LH positive
    do_req(0, 32'h11,       32'h0,        2'b00, 0,   32'h0000005A, 32'h0,        0); // LB lane 1
    do_req(0, 32'h10,       32'h0,        2'b00, 0,   32'hFFFFFFEF, 32'h0,        0); // LB lane 0
    do_req(1, 32'h13,       32'h00000080, 2'b00, 0,   32'h0,        32'h80EF5AEF, 0); // SB lane 3
    do_req(0, 32'h13,       32'h0,        2'b00, 0,   32'hFFFFFF80, 32'h0,        0); // LB lane 3
    // Fault candidates: misaligned word/half, high address bits.
    do_req(0, 32'h2,        32'h0,        2'b10, 0,   32'h11223344, 32'h0,        1); // LW @0x2
    do_req(0, 32'h13,       32'h0,        2'b01, 0,   32'hFFFF80EF, 32'h0,        1); // LH @0x13
    do_req(0, 32'h1010,     32'h0,        2'b10, 0,   32'h80EF5AEF, 32'h0,        1); // LW wraps

    repeat (5) @(negedge clk);
    check("resp_q_drained", resp_q.size(), 32'h0);
    check("rd_q_drained", rd_q.size(), 32'h0);
    check("wr_q_drained", wr_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z_core_mem_ctrl.md
Name: z_core_mem_ctrl

Overview:
- Data-memory controller directly downstream of z_core_control_u; consumes its load/store requests and drives a single-port synchronous word RAM.
- Handles RV32I access sizes: word stores written directly; byte/half stores via read-modify-write; loads extracted and sign/zero-extended.
- One request in flight; single-cycle ready pulse back to the control unit.

Parameters:
- ADDR_W, 10, RAM word-address width (RAM depth = 2**ADDR_W words).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- core_req  in  1  access request, sampled only in IDLE
- core_we  in  1  1 = store, 0 = load
- core_addr  in  32  byte address
- core_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- core_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- core_unsigned  in  1  1 = zero-extend load (LBU/LHU)
- core_rdata  out  32  load result, valid while core_ready=1
- core_ready  out  1  one-cycle completion pulse
- core_err  out  1  access fault, valid with core_ready
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address = core_addr[ADDR_W+1:2]
- mem_wdata  out  32  RAM write word
- mem_rdata  in  32  RAM read word, valid the cycle after a read enable

Behaviour:
- Reset: state IDLE; core_rdata=0, core_ready=0, core_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; latched request and read buffer cleared.
- States: IDLE, RD, CAP, WR, RESP. All outputs registered or decoded from state and latched request only.
- IDLE: core_req=1 at edge N latches we/addr/wdata/size/unsigned. Next state: word store -> WR; load or sub-word store -> RD.
- RD (one cycle): mem_en=1, mem_we=0. Next state: CAP.
- CAP (one cycle): mem_rdata valid; captured into buffer at end of cycle. Next state: load -> RESP; sub-word store -> WR.
- WR (one cycle): mem_en=1, mem_we=1. mem_wdata = word store ? wdata : buffer with selected lane(s) replaced. Next state: RESP.
- RESP (one cycle): core_ready=1, core_err=0. Loads present extracted core_rdata; stores present core_rdata=0. Next state: IDLE.
- Latency from acceptance edge N, core_ready high during cycle: load N+3; byte/half store N+4; word store N+2.
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1]. Loads sign-extend bit 7/15 unless core_unsigned=1; word load ignores core_unsigned.
- core_req is ignored outside IDLE; input changes after acceptance have no effect. core_req held high through RESP is accepted at the edge after RESP, giving one idle cycle between back-to-back requests.
- mem_en=0 in IDLE, CAP and RESP. Address wraps modulo RAM depth; upper core_addr bits are ignored unless the optional feature is enabled.
- Reset during any state: IDLE at the next edge; no core_ready, and no RAM write in the following cycle. A read-modify-write in progress is abandoned with the RAM unmodified.

Optional Feature:
- Macro Z_CORE_MEM_FAULT_EN.
- Defined: a request is faulted if it is a misaligned half (addr[0]=1), a misaligned word (addr[1:0]!=0), core_size=11, or any core_addr[31:ADDR_W+2] bit is set.
  - Faulted requests go IDLE -> RESP with no RAM access.
  - core_ready=1 and core_err=1 during N+1; core_rdata=0.
- Not defined: core_err tied 0; core_size=11 treated as word. Misalignment is not checked; word/half use the aligned containing word and half-lane addr[1].

Test Plan:
- Reset, then SW 0xDEADBEEF @0x10 -> WR cycle with mem_addr=4, mem_wdata=0xDEADBEEF; core_ready pulse at N+2.
- After the above, SB 0x5A @0x11 -> RD then WR at mem_addr=4 with mem_wdata=0xDEAD5AEF; core_ready at N+4.
- LB @0x13 with word 0xDEAD5AEF -> core_rdata=0xFFFFFFDE at N+3; LBU -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LW @0x10 -> 0xDEAD5AEF.
- core_req held high for two LW @0x0 -> two single-cycle core_ready pulses, one idle cycle between RESP and the second acceptance.
- reset asserted during the RD cycle of SH 0x1234 @0x10 -> no mem_we pulse, no core_ready; subsequent LW @0x10 returns the unchanged word.
- With Z_CORE_MEM_FAULT_EN, LW @0x2 -> core_ready=1, core_err=1 at N+1, mem_en never asserted. Without the macro, the same request reads word 0.
